// File: rtl/jtvigil_romarb_pkg.sv
// Shared types and constants for the Vigilante ROM arbiter.
// The optional per-requester word cache is enabled with JTVIGIL_ROMARB_CACHE_EN.
package jtvigil_romarb_pkg;

   localparam int unsigned SW_DEF   = 22;
   localparam int unsigned NREQ     = 3;
   localparam int unsigned MAIN_AW  = 18;
   localparam int unsigned SND_AW   = 15;
   localparam int unsigned PCM_AW   = 16;

   typedef enum logic { IDLE = 1'b0, WAIT = 1'b1 } state_t;

   typedef logic [1:0] req_t;
   localparam req_t MAIN = 2'd0;
   localparam req_t SND  = 2'd1;
   localparam req_t PCM  = 2'd2;

   localparam logic [21:0] MAIN_OFFSET_DEF = 22'h00_0000;
   localparam logic [21:0] SND_OFFSET_DEF  = 22'h01_0000;
   localparam logic [21:0] PCM_OFFSET_DEF  = 22'h01_8000;

   // Round-robin successor: main -> snd -> pcm -> main
   function automatic req_t next_req(input req_t r);
      return (r == PCM) ? MAIN : req_t'(r + 2'd1);
   endfunction

endpackage

// File: rtl/jtvigil_romarb_slot.sv
// One requester's address latch, valid flag, data byte and ok compare.
// With JTVIGIL_ROMARB_CACHE_EN the last fetched word also serves the sibling byte.
module jtvigil_romarb_slot
   import jtvigil_romarb_pkg::*;
#(
   parameter int unsigned AW = 16
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          grant,
   input  logic          done,
   input  logic          busy,
   input  logic [15:0]   dout,
   output logic [7:0]    data,
   output logic          ok,
   output logic          pending
);

   logic [AW-1:0] lat;
   logic          valid;
   logic          match;
   logic          hit;

   assign match   = valid && (lat == addr);
   assign ok      = cs && match;
   assign pending = cs && !match && !hit && !busy;

`ifdef JTVIGIL_ROMARB_CACHE_EN
   logic [15:0]   cword;
   logic [AW-2:0] cwaddr;
   logic          cvalid;

   // Never hit while our own SDRAM access is outstanding
   assign hit = cs && !match && !busy && cvalid && (cwaddr == addr[AW-1:1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cword  <= '0;
         cwaddr <= '0;
         cvalid <= 1'b0;
      end else if (done) begin
         cword  <= dout;
         cwaddr <= lat[AW-1:1];
         cvalid <= 1'b1;
      end
   end
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat   <= '0;
         valid <= 1'b0;
         data  <= '0;
      end else begin
         if (grant) begin
            lat   <= addr;
            valid <= 1'b0;
         end else if (done) begin
            valid <= 1'b1;
            data  <= lat[0] ? dout[15:8] : dout[7:0];
         end
`ifdef JTVIGIL_ROMARB_CACHE_EN
         else if (hit) begin
            lat   <= addr;
            valid <= 1'b1;
            data  <= addr[0] ? cword[15:8] : cword[7:0];
         end
`endif
      end
   end

endmodule

// File: rtl/jtvigil_romarb.sv
// Round-robin arbiter sharing one 16-bit SDRAM read port among main, sound and PCM ROMs.
// Optional word cache per requester: define JTVIGIL_ROMARB_CACHE_EN.
module jtvigil_romarb
   import jtvigil_romarb_pkg::*;
#(
   parameter int unsigned     SW          = SW_DEF,
   parameter logic [SW-1:0]   MAIN_OFFSET = SW'(MAIN_OFFSET_DEF),
   parameter logic [SW-1:0]   SND_OFFSET  = SW'(SND_OFFSET_DEF),
   parameter logic [SW-1:0]   PCM_OFFSET  = SW'(PCM_OFFSET_DEF)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               main_cs,
   input  logic [MAIN_AW-1:0] main_addr,
   output logic [7:0]         main_data,
   output logic               main_ok,
   input  logic               snd_cs,
   input  logic [SND_AW-1:0]  snd_addr,
   output logic [7:0]         snd_data,
   output logic               snd_ok,
   input  logic               pcm_cs,
   input  logic [PCM_AW-1:0]  pcm_addr,
   output logic [7:0]         pcm_data,
   output logic               pcm_ok,
   output logic               sdram_cs,
   output logic [SW-1:0]      sdram_addr,
   input  logic [15:0]        sdram_dout,
   input  logic               sdram_ok
);

   state_t          st, st_nxt;
   req_t            ptr, ptr_nxt;
   req_t            sel, sel_nxt;
   req_t            cand;
   logic            found;
   logic            cs_nxt;
   logic [SW-1:0]   addr_nxt;
   logic [NREQ-1:0] pend, grant, done, busy;
   logic [SW-1:0]   word [NREQ];

   // Offset addition wraps modulo 2^SW
   assign word[MAIN] = MAIN_OFFSET + SW'(main_addr[MAIN_AW-1:1]);
   assign word[SND]  = SND_OFFSET  + SW'(snd_addr[SND_AW-1:1]);
   assign word[PCM]  = PCM_OFFSET  + SW'(pcm_addr[PCM_AW-1:1]);

   assign busy[MAIN] = (st == WAIT) && (sel == MAIN);
   assign busy[SND]  = (st == WAIT) && (sel == SND);
   assign busy[PCM]  = (st == WAIT) && (sel == PCM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= IDLE;
         ptr        <= MAIN;
         sel        <= MAIN;
         sdram_cs   <= 1'b0;
         sdram_addr <= '0;
      end else begin
         st         <= st_nxt;
         ptr        <= ptr_nxt;
         sel        <= sel_nxt;
         sdram_cs   <= cs_nxt;
         sdram_addr <= addr_nxt;
      end
   end

   always_comb begin
      st_nxt   = st;
      ptr_nxt  = ptr;
      sel_nxt  = sel;
      cs_nxt   = sdram_cs;
      addr_nxt = sdram_addr;
      grant    = '0;
      done     = '0;
      found    = 1'b0;
      cand     = ptr;
      case (st)
         IDLE: begin
            // First pending requester starting at the pointer
            for (int i = 0; i < int'(NREQ); i++) begin
               if (!found && pend[cand]) begin
                  found   = 1'b1;
                  sel_nxt = cand;
               end
               cand = next_req(cand);
            end
            if (found) begin
               grant[sel_nxt] = 1'b1;
               cs_nxt         = 1'b1;
               addr_nxt       = word[sel_nxt];
               st_nxt         = WAIT;
            end
         end
         WAIT: begin
            if (sdram_ok) begin
               done[sel] = 1'b1;
               cs_nxt    = 1'b0;
               ptr_nxt   = next_req(sel);
               st_nxt    = IDLE;
            end
         end
         default: st_nxt = IDLE;
      endcase
   end

   jtvigil_romarb_slot #(.AW(MAIN_AW)) u_main (
      .clk(clk), .rst(rst), .cs(main_cs), .addr(main_addr),
      .grant(grant[MAIN]), .done(done[MAIN]), .busy(busy[MAIN]), .dout(sdram_dout),
      .data(main_data), .ok(main_ok), .pending(pend[MAIN])
   );

   jtvigil_romarb_slot #(.AW(SND_AW)) u_snd (
      .clk(clk), .rst(rst), .cs(snd_cs), .addr(snd_addr),
      .grant(grant[SND]), .done(done[SND]), .busy(busy[SND]), .dout(sdram_dout),
      .data(snd_data), .ok(snd_ok), .pending(pend[SND])
   );

   jtvigil_romarb_slot #(.AW(PCM_AW)) u_pcm (
      .clk(clk), .rst(rst), .cs(pcm_cs), .addr(pcm_addr),
      .grant(grant[PCM]), .done(done[PCM]), .busy(busy[PCM]), .dout(sdram_dout),
      .data(pcm_data), .ok(pcm_ok), .pending(pend[PCM])
   );

endmodule

// File: tb/tb_jtvigil_romarb.sv
// Directed bench for jtvigil_romarb with an SDRAM responder and a ROM-content model.
// Expectations for the cached build follow JTVIGIL_ROMARB_CACHE_EN.
module tb_jtvigil_romarb;

   logic        clk = 1'b0;
   logic        rst;
   logic        main_cs, snd_cs, pcm_cs;
   logic [17:0] main_addr;
   logic [14:0] snd_addr;
   logic [15:0] pcm_addr;
   logic [7:0]  main_data, snd_data, pcm_data;
   logic        main_ok, snd_ok, pcm_ok;
   logic        sdram_cs, sdram_ok;
   logic [21:0] sdram_addr;
   logic [15:0] sdram_dout;

   int          total = 0;
   int          bad   = 0;
   int          n_acc = 0;
   logic [21:0] acc_q[$];
   bit          inject = 1'b0;
   int          lat_cyc = 4;

   always #5 clk = ~clk;

   jtvigil_romarb dut (
      .clk(clk), .rst(rst),
      .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
      .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_data(snd_data), .snd_ok(snd_ok),
      .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
      .sdram_cs(sdram_cs), .sdram_addr(sdram_addr), .sdram_dout(sdram_dout), .sdram_ok(sdram_ok)
   );

   // ROM contents as seen through the SDRAM, word addressed
   function automatic logic [15:0] mem_word(input logic [21:0] w);
      if (w == 22'h000080) return 16'hA55A;
      return {w[7:0] ^ 8'h5C, w[15:8] ^ w[7:0] ^ 8'hA3};
   endfunction

   function automatic logic [7:0] exp_byte(input logic [21:0] off, input logic [17:0] ba);
      logic [21:0] w;
      logic [15:0] d;
      w = off + 22'(ba >> 1);
      d = mem_word(w);
      return ba[0] ? d[15:8] : d[7:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic wait_cs(input string name);
      int n = 0;
      @(negedge clk);
      while (!sdram_cs && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!sdram_cs) begin
         total++;
         bad++;
         $display("FAIL %s timeout waiting for sdram_cs", name);
      end
   endtask

   task automatic wait_ok(input string name);
      int n = 0;
      @(negedge clk);
      while (!sdram_ok && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!sdram_ok) begin
         total++;
         bad++;
         $display("FAIL %s timeout waiting for sdram_ok", name);
      end
   endtask

   // SDRAM responder: fixed latency after cs, one-cycle ok pulse
   initial begin : resp
      int cnt;
      cnt        = 0;
      sdram_ok   = 1'b0;
      sdram_dout = '0;
      forever begin
         @(posedge clk);
         #1;
         sdram_ok = 1'b0;
         if (inject) begin
            sdram_ok   = 1'b1;
            sdram_dout = 16'hFFFF;
            inject     = 1'b0;
            cnt        = 0;
         end else if (rst || !sdram_cs) begin
            cnt = 0;
         end else begin
            cnt++;
            if (cnt == lat_cyc) begin
               sdram_dout = mem_word(sdram_addr);
               sdram_ok   = 1'b1;
               acc_q.push_back(sdram_addr);
               n_acc++;
               cnt = 0;
            end
         end
      end
   end

   // Every-cycle check: any flagged byte must be the ROM byte at the current address
   logic [21:0] prev_addr = '0;
   logic        prev_cs = 1'b0;
   logic        prev_ok = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (main_ok) chk("main_data_model", 32'(main_data), 32'(exp_byte(22'h000000, main_addr)));
         if (snd_ok)  chk("snd_data_model",  32'(snd_data),  32'(exp_byte(22'h010000, 18'(snd_addr))));
         if (pcm_ok)  chk("pcm_data_model",  32'(pcm_data),  32'(exp_byte(22'h018000, 18'(pcm_addr))));
         if (!main_cs) chk("main_ok_nocs", 32'(main_ok), 32'd0);
         if (!snd_cs)  chk("snd_ok_nocs",  32'(snd_ok),  32'd0);
         if (!pcm_cs)  chk("pcm_ok_nocs",  32'(pcm_ok),  32'd0);
         if (sdram_cs && prev_cs && !prev_ok)
            chk("sdram_addr_hold", 32'(sdram_addr), 32'(prev_addr));
      end
      prev_cs   = sdram_cs;
      prev_ok   = sdram_ok;
      prev_addr = sdram_addr;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin : main_seq
      int base;
      int exp_acc;
      rst = 1'b1;
      main_cs = 1'b1; snd_cs = 1'b1; pcm_cs = 1'b1;
      main_addr = '0; snd_addr = '0; pcm_addr = '0;
      repeat (3) @(negedge clk);
      chk("rst_sdram_cs",   32'(sdram_cs),   32'd0);
      chk("rst_sdram_addr", 32'(sdram_addr), 32'd0);
      chk("rst_main_data",  32'(main_data),  32'd0);
      chk("rst_snd_data",   32'(snd_data),   32'd0);
      chk("rst_pcm_data",   32'(pcm_data),   32'd0);
      chk("rst_main_ok",    32'(main_ok),    32'd0);
      chk("rst_snd_ok",     32'(snd_ok),     32'd0);
      chk("rst_pcm_ok",     32'(pcm_ok),     32'd0);
      main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      // Main alone, odd byte of word 0x80
      @(posedge clk); #1;
      main_addr = 18'h00101; main_cs = 1'b1;
      wait_cs("t1_cs");
      chk("t1_sdram_addr", 32'(sdram_addr), 32'h000080);
      wait_ok("t1_ok");
      chk("t1_ok_early", 32'(main_ok), 32'd0);
      @(negedge clk);
      chk("t1_main_ok",   32'(main_ok),   32'd1);
      chk("t1_main_data", 32'(main_data), 32'hA5);
      @(posedge clk); #1 main_cs = 1'b0;

      // All three at once with the pointer back at main
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      acc_q.delete();
      main_addr = 18'h00204; snd_addr = 15'h1235; pcm_addr = 16'h0ABC;
      main_cs = 1'b1; snd_cs = 1'b1; pcm_cs = 1'b1;
      wait_ok("t2_ok0");
      @(negedge clk);
      chk("t2_main_ok0", 32'(main_ok), 32'd1);
      chk("t2_snd_ok0",  32'(snd_ok),  32'd0);
      chk("t2_pcm_ok0",  32'(pcm_ok),  32'd0);
      wait_ok("t2_ok1");
      @(negedge clk);
      chk("t2_snd_ok1",  32'(snd_ok),  32'd1);
      chk("t2_pcm_ok1",  32'(pcm_ok),  32'd0);
      chk("t2_snd_data", 32'(snd_data), 32'h46);
      wait_ok("t2_ok2");
      @(negedge clk);
      chk("t2_pcm_ok2",  32'(pcm_ok),  32'd1);
      chk("t2_nacc", 32'(acc_q.size()), 32'd3);
      if (acc_q.size() == 3) begin
         chk("t2_grant0", 32'(acc_q[0]), 32'h000102);
         chk("t2_grant1", 32'(acc_q[1]), 32'h01091A);
         chk("t2_grant2", 32'(acc_q[2]), 32'h01855E);
      end
      @(posedge clk); #1;
      main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0;

      // Main moves to another word while its access is in flight
      @(posedge clk); #1;
      main_addr = 18'h00010; main_cs = 1'b1;
      wait_cs("t3_cs0");
      chk("t3_sdram_addr0", 32'(sdram_addr), 32'h000008);
      @(posedge clk); #1 main_addr = 18'h00012;
      wait_ok("t3_ok0");
      @(negedge clk);
      chk("t3_main_ok_stale", 32'(main_ok), 32'd0);
      wait_cs("t3_cs1");
      chk("t3_sdram_addr1", 32'(sdram_addr), 32'h000009);
      wait_ok("t3_ok1");
      @(negedge clk);
      chk("t3_main_ok",   32'(main_ok),   32'd1);
      chk("t3_main_data", 32'(main_data), 32'hAA);
      @(posedge clk); #1 main_cs = 1'b0;

      // Reset in the middle of a sound access
      @(posedge clk); #1;
      snd_addr = 15'h0042; snd_cs = 1'b1;
      wait_cs("t4_cs0");
      @(posedge clk); #2 rst = 1'b1;
      #1;
      chk("t4_rst_sdram_cs",   32'(sdram_cs),   32'd0);
      chk("t4_rst_sdram_addr", 32'(sdram_addr), 32'd0);
      chk("t4_rst_snd_data",   32'(snd_data),   32'd0);
      chk("t4_rst_main_data",  32'(main_data),  32'd0);
      chk("t4_rst_pcm_data",   32'(pcm_data),   32'd0);
      chk("t4_rst_snd_ok",     32'(snd_ok),     32'd0);
      @(posedge clk); #1 rst = 1'b0;
      wait_cs("t4_cs1");
      chk("t4_sdram_addr", 32'(sdram_addr), 32'h010021);
      wait_ok("t4_ok");
      @(negedge clk);
      chk("t4_snd_ok",   32'(snd_ok),   32'd1);
      chk("t4_snd_data", 32'(snd_data), 32'h82);
      @(posedge clk); #1 snd_cs = 1'b0;

      // PCM reads both bytes of one word
      @(posedge clk); #1;
      pcm_addr = 16'h0004; pcm_cs = 1'b1;
      wait_ok("t5_ok0");
      @(negedge clk);
      chk("t5_pcm_ok0",   32'(pcm_ok),   32'd1);
      chk("t5_pcm_data0", 32'(pcm_data), 32'h21);
      base = n_acc;
      @(posedge clk); #1 pcm_addr = 16'h0005;
      @(negedge clk);
      chk("t5_pcm_ok_drop", 32'(pcm_ok), 32'd0);
`ifdef JTVIGIL_ROMARB_CACHE_EN
      exp_acc = 0;
      @(negedge clk);
      chk("t5_cache_ok",   32'(pcm_ok),   32'd1);
      chk("t5_cache_data", 32'(pcm_data), 32'h5E);
`else
      exp_acc = 1;
`endif
      repeat (12) @(negedge clk);
      chk("t5_accesses", 32'(n_acc - base), 32'(exp_acc));
      chk("t5_pcm_ok1",   32'(pcm_ok),   32'd1);
      chk("t5_pcm_data1", 32'(pcm_data), 32'h5E);

      // Stray sdram_ok while idle must not disturb anything
      @(negedge clk) inject = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      main_addr = 18'h00000; main_cs = 1'b1;
      @(negedge clk);
      chk("t6_main_ok",   32'(main_ok),   32'd0);
      chk("t6_main_data", 32'(main_data), 32'd0);
      chk("t6_pcm_ok",    32'(pcm_ok),    32'd1);
      chk("t6_pcm_data",  32'(pcm_data),  32'h5E);
      chk("t6_sdram_cs",  32'(sdram_cs),  32'd0);
      wait_ok("t6_ok");
      @(negedge clk);
      chk("t6_main_ok_after",   32'(main_ok),   32'd1);
      chk("t6_main_data_after", 32'(main_data), 32'hA3);
      @(posedge clk); #1;
      main_cs = 1'b0; pcm_cs = 1'b0;
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jtvigil_romarb.md
Name: jtvigil_romarb

Overview:
- Shares one SDRAM read port between three 8-bit ROM requesters: main CPU program/banked ROM, sound CPU ROM and PCM sample ROM.
- Sits between the CPU/sound wrappers and the jtframe SDRAM bank interface.
- Each requester gets a cs/ok handshake of the kind the CPU wrappers already expect. The SDRAM port is 16-bit and word-addressed; the arbiter does byte selection.

Parameters:
SW, 22, SDRAM word-address width.
MAIN_OFFSET, 22'h00_0000, word offset of main ROM region.
SND_OFFSET, 22'h01_0000, word offset of sound ROM region.
PCM_OFFSET, 22'h01_8000, word offset of PCM region.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
main_cs  in  1  main CPU ROM request.
main_addr  in  18  main byte address.
main_data  out  8  main read data.
main_ok  out  1  main data valid for current main_addr.
snd_cs  in  1  sound ROM request.
snd_addr  in  15  sound byte address.
snd_data  out  8  sound read data.
snd_ok  out  1  sound data valid.
pcm_cs  in  1  PCM request.
pcm_addr  in  16  PCM byte address.
pcm_data  out  8  PCM read data.
pcm_ok  out  1  PCM data valid.
sdram_cs  out  1  SDRAM read request, held until sdram_ok.
sdram_addr  out  SW  SDRAM word address.
sdram_dout  in  16  SDRAM read word.
sdram_ok  in  1  SDRAM read complete, one-cycle pulse.

Behaviour:
- Reset (async): state IDLE, sdram_cs=0, sdram_addr=0, all *_data=0, all *_ok=0, round-robin pointer=main, all valid flags clear.
- Per requester, register:
  - latched byte address;
  - captured data byte;
  - valid flag.
- *_ok = *_cs && valid && (latched addr == current addr), combinational.
  - ok falls in the same cycle the address changes or cs drops; no stale data is ever flagged valid.
- Pending(n) = cs(n) && !(valid(n) && addr match).
- State machine:
  - IDLE: if any requester is pending, grant the first pending one in round-robin order starting at the pointer (main -> snd -> pcm -> main).
    - On grant: latch the requester's byte address, drive sdram_addr = OFFSET + (byte addr >> 1), set sdram_cs=1, clear that requester's valid, go to WAIT.
  - WAIT: hold sdram_cs and sdram_addr stable.
    - On sdram_ok: store sdram_dout[7:0] if latched addr[0]==0, else sdram_dout[15:8].
    - Same edge: set valid, sdram_cs=0, advance the pointer to the requester after the granted one, go to IDLE.
  - Minimum turnaround: grant-to-ok = SDRAM latency + 1 cycle. IDLE lasts one cycle between accesses, so a new grant never coincides with sdram_ok.
- Address-offset addition is SW bits wide and wraps modulo 2^SW; no saturation.
- Requester changes address while in WAIT:
  - the access completes and data is stored against the old latched address, so ok stays low;
  - the requester re-pends and is re-granted on a later pass.
- cs drops while in WAIT: access completes and data is stored; no abort on the SDRAM side.
- All three requesters pending: served in round-robin order; each waits at most two other accesses.
- sdram_ok while in IDLE: ignored.
- rst asserted mid-access: immediate return to reset values. The SDRAM controller must tolerate a dropped cs; that is the jtframe convention.

Optional Feature:
- Macro: JTVIGIL_ROMARB_CACHE_EN.
- Defined:
  - each requester keeps its last full 16-bit word plus word address.
  - A new request to the other byte of the cached word fills data and sets valid in the next cycle without an SDRAM access or grant.
  - The cache is invalidated by reset only.
- Undefined: every address miss goes through the SDRAM state machine; no word storage.

Decomposition:
- Package jtvigil_romarb_pkg holds:
  - state encoding (IDLE, WAIT);
  - requester index constants (MAIN=0, SND=1, PCM=2);
  - offset defaults.
- One sub-module, jtvigil_romarb_slot, instantiated three times:
  - per-requester address latch, valid flag, data capture, ok compare;
  - cache word under the macro.

Test Plan:
- Main only: main_cs=1, addr 18'h00101, sdram_ok after 4 cycles with sdram_dout=16'hA55A.
  - sdram_addr=22'h000080; main_data=8'hA5; main_ok high from the cycle after sdram_ok.
- All three request at once, pointer at main:
  - grants ordered main, snd, pcm;
  - snd sdram_addr = 22'h010000 + (snd_addr >> 1);
  - each ok asserts only after its own sdram_ok.
- Main changes addr 0x0010 -> 0x0012 during WAIT:
  - main_ok stays 0 after the first sdram_ok;
  - second access issued to word 0x0009; ok after it.
- rst pulsed during WAIT: all outputs 0 within the reset cycle; the request after release re-issues correctly.
- With cache: pcm addr 16'h0004 then 16'h0005.
  - Second request produces no sdram_cs pulse; pcm_data equals dout[15:8] of the first word one cycle later.
  - Without the macro: two SDRAM accesses.
- sdram_ok pulse while IDLE: no output changes, no valid set.
